// File: rtl/ss_detect_pkg.sv
// ss_detect_pkg
// Shared types and helpers for the multi-lane stream-start detector.
//   lane_state_t : per-lane FSM state (IDLE / LOCKED)
//   MAX_WORD_W   : widest lane word the static-word helper accepts
//   qual_cnt_w   : width of the qualification counter for a given START_CNT
//   loss_cnt_w   : width of the loss counter for a given LOSS_CNT (never 0)
//   is_static    : 1 when the low cmp_w bits of a word are all 0 or all 1
package ss_detect_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lane_state_t;

    localparam int MAX_WORD_W = 64;

    function automatic int qual_cnt_w(input int start_cnt);
        return $clog2(start_cnt + 1);
    endfunction

    // LOSS_CNT = 0 would give a zero-width counter; keep at least one bit.
    function automatic int loss_cnt_w(input int loss_cnt);
        return (loss_cnt > 0) ? $clog2(loss_cnt + 1) : 1;
    endfunction

    // Only the low cmp_w bits take part; higher bits are masked away.
    // cmp_w must be below MAX_WORD_W.
    function automatic logic is_static(input logic [MAX_WORD_W-1:0] word,
                                       input int                    cmp_w);
        logic [MAX_WORD_W-1:0] mask;
        mask = (MAX_WORD_W'(1) << cmp_w) - MAX_WORD_W'(1);
        return ((word & mask) == '0) || ((word & mask) == mask);
    endfunction

endpackage

// File: rtl/ss_detect_lane.sv
// ss_detect_lane
// One lane of the stream-start detector: IDLE/LOCKED FSM with a
// qualification counter (consecutive non-static words) and a loss
// counter (consecutive static words while locked).
// Ports:
//   rck          : word clock, posedge
//   rst          : asynchronous active-high reset
//   rearm        : synchronous return to IDLE (no loss pulse)
//   en           : lane enable; 0 holds the lane in IDLE
//   word         : current lane word
//   stream_start : 1 while the lane is LOCKED
//   lock_lost    : one-cycle pulse when lock is dropped by static-word loss
module ss_detect_lane
    import ss_detect_pkg::*;
#(
    parameter int DATA_W    = 10,
    parameter int CMP_W     = 7,
    parameter int START_CNT = 2,
    parameter int LOSS_CNT  = 16
) (
    input  logic              rck,
    input  logic              rst,
    input  logic              rearm,
    input  logic              en,
    input  logic [DATA_W-1:0] word,
    output logic              stream_start,
    output logic              lock_lost
);

    localparam int QW = qual_cnt_w(START_CNT);
    localparam int LW = loss_cnt_w(LOSS_CNT);

    // Counter value held when the qualifying/losing word arrives.
    localparam logic [QW-1:0] QUAL_LAST = QW'(START_CNT - 1);
    localparam logic [LW-1:0] LOSS_LAST = (LOSS_CNT > 0) ? LW'(LOSS_CNT - 1) : '0;

    lane_state_t   state_reg;
    logic [QW-1:0] qual_reg;
    logic [LW-1:0] loss_reg;
    logic          lost_reg;
    logic          word_static;

    assign word_static = is_static(MAX_WORD_W'(word), CMP_W);

    always_ff @(posedge rck or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            qual_reg  <= '0;
            loss_reg  <= '0;
            lost_reg  <= 1'b0;
        end else begin
            lost_reg <= 1'b0;
            if (rearm || !en) begin
                state_reg <= IDLE;
                qual_reg  <= '0;
                loss_reg  <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        loss_reg <= '0;
                        if (word_static) begin
                            qual_reg <= '0;
                        end else if (qual_reg == QUAL_LAST) begin
                            state_reg <= LOCKED;
                            qual_reg  <= '0;
                        end else begin
                            qual_reg <= qual_reg + QW'(1);
                        end
                    end
                    LOCKED: begin
                        qual_reg <= '0;
                        // With LOSS_CNT = 0 the lock is sticky.
                        if (LOSS_CNT > 0) begin
                            if (!word_static) begin
                                loss_reg <= '0;
                            end else if (loss_reg == LOSS_LAST) begin
                                // Losing word is not reused for requalification.
                                state_reg <= IDLE;
                                loss_reg  <= '0;
                                lost_reg  <= 1'b1;
                            end else begin
                                loss_reg <= loss_reg + LW'(1);
                            end
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        qual_reg  <= '0;
                        loss_reg  <= '0;
                    end
                endcase
            end
        end
    end

    assign stream_start = (state_reg == LOCKED);
    assign lock_lost    = lost_reg;

endmodule

// File: rtl/ss_detect_multi.sv
// ss_detect_multi
// Multi-lane stream-start detector: LANES independent ss_detect_lane
// instances plus a registered "all enabled lanes started" flag.
// Ports:
//   rck          : word clock, posedge
//   rst          : asynchronous active-high reset
//   rearm        : synchronous, forces every lane to IDLE
//   lane_en      : per-lane enable
//   rx_data      : lane words, lane i at [i*DATA_W +: DATA_W]
//   stream_start : per-lane lock indication
//   all_start    : registered AND of stream_start over enabled lanes
//   lock_lost    : per-lane one-cycle loss-of-lock pulse
module ss_detect_multi
    import ss_detect_pkg::*;
#(
    parameter int DATA_W    = 10,
    parameter int CMP_W     = 7,
    parameter int LANES     = 1,
    parameter int START_CNT = 2,
    parameter int LOSS_CNT  = 16
) (
    input  logic                    rck,
    input  logic                    rst,
    input  logic                    rearm,
    input  logic [LANES-1:0]        lane_en,
    input  logic [LANES*DATA_W-1:0] rx_data,
    output logic [LANES-1:0]        stream_start,
    output logic                    all_start,
    output logic [LANES-1:0]        lock_lost
);

    logic all_start_reg;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            ss_detect_lane #(
                .DATA_W    (DATA_W),
                .CMP_W     (CMP_W),
                .START_CNT (START_CNT),
                .LOSS_CNT  (LOSS_CNT)
            ) u_lane (
                .rck          (rck),
                .rst          (rst),
                .rearm        (rearm),
                .en           (lane_en[gi]),
                .word         (rx_data[gi*DATA_W +: DATA_W]),
                .stream_start (stream_start[gi]),
                .lock_lost    (lock_lost[gi])
            );
        end
    endgenerate

    // Disabled lanes are masked to 1 so they do not block the AND;
    // with no lane enabled the flag stays low.
    always_ff @(posedge rck or posedge rst) begin
        if (rst) begin
            all_start_reg <= 1'b0;
        end else begin
            all_start_reg <= (|lane_en) && (&(stream_start | ~lane_en));
        end
    end

    assign all_start = all_start_reg;

endmodule

// File: tb/tb_ss_detect_multi.sv
// tb_ss_detect_multi
// Two detectors share one stimulus stream:
//   dut_a : LANES=4, START_CNT=2, LOSS_CNT=3
//   dut_b : LANES=1, START_CNT=4, LOSS_CNT=0 (sticky), fed lane 0
// A history-window model predicts every output each cycle; directed
// literal checks pin the model at the interesting points.
module tb_ss_detect_multi;

    logic        rck = 1'b0;
    logic        rst;
    logic        rearm;
    logic [3:0]  lane_en;
    logic [39:0] rx_data;

    logic [3:0]  ss_a, lost_a;
    logic        all_a;
    logic        ss_b, all_b, lost_b;

    int checks = 0;
    int errors = 0;

    always #5 rck = ~rck;

    ss_detect_multi #(
        .DATA_W(10), .CMP_W(7), .LANES(4), .START_CNT(2), .LOSS_CNT(3)
    ) dut_a (
        .rck          (rck),
        .rst          (rst),
        .rearm        (rearm),
        .lane_en      (lane_en),
        .rx_data      (rx_data),
        .stream_start (ss_a),
        .all_start    (all_a),
        .lock_lost    (lost_a)
    );

    ss_detect_multi #(
        .DATA_W(10), .CMP_W(7), .LANES(1), .START_CNT(4), .LOSS_CNT(0)
    ) dut_b (
        .rck          (rck),
        .rst          (rst),
        .rearm        (rearm),
        .lane_en      (lane_en[0:0]),
        .rx_data      (rx_data[9:0]),
        .stream_start (ss_b),
        .all_start    (all_b),
        .lock_lost    (lost_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each lane remembers which past words were static. A lane locks when
    // the last START_CNT words since it was armed are all non-static, and
    // (LOSS_CNT>0) loses lock when the last LOSS_CNT words since locking
    // are all static.
    bit hist   [2][4][1024];
    int m_arm  [2][4];
    int m_lkat [2][4];
    bit m_lock [2][4];
    bit m_lost [2][4];
    bit m_all  [2];
    int ncyc = 0;

    function automatic bit stat(input logic [9:0] w);
        return (w[6:0] == 7'h00) || (w[6:0] == 7'h7f);
    endfunction

    always @(posedge rck or posedge rst) begin
        int  n, sc, lc, nl;
        bit  any_en, ok, en_l, win;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_all[d] = 1'b0;
                for (int l = 0; l < 4; l++) begin
                    m_lock[d][l] = 1'b0;
                    m_lost[d][l] = 1'b0;
                    m_arm[d][l]  = ncyc;
                end
            end
        end else begin
            n = ncyc;
            for (int d = 0; d < 2; d++) begin
                nl = (d == 0) ? 4 : 1;
                sc = (d == 0) ? 2 : 4;
                lc = (d == 0) ? 3 : 0;
                any_en = 1'b0;
                ok     = 1'b1;
                for (int l = 0; l < nl; l++) begin
                    en_l = lane_en[l];
                    if (en_l) begin
                        any_en = 1'b1;
                        if (!m_lock[d][l]) ok = 1'b0;
                    end
                end
                m_all[d] = any_en && ok;
                for (int l = 0; l < nl; l++) begin
                    en_l = lane_en[l];
                    hist[d][l][n % 1024] = stat(rx_data[l*10 +: 10]);
                    m_lost[d][l] = 1'b0;
                    if (rearm || !en_l) begin
                        m_lock[d][l] = 1'b0;
                        m_arm[d][l]  = n + 1;
                    end else if (!m_lock[d][l]) begin
                        if (n - m_arm[d][l] + 1 >= sc) begin
                            win = 1'b1;
                            for (int k = n - sc + 1; k <= n; k++)
                                if (hist[d][l][k % 1024]) win = 1'b0;
                            if (win) begin
                                m_lock[d][l] = 1'b1;
                                m_lkat[d][l] = n + 1;
                            end
                        end
                    end else if (lc > 0 && (n - m_lkat[d][l] + 1 >= lc)) begin
                        win = 1'b1;
                        for (int k = n - lc + 1; k <= n; k++)
                            if (!hist[d][l][k % 1024]) win = 1'b0;
                        if (win) begin
                            m_lock[d][l] = 1'b0;
                            m_lost[d][l] = 1'b1;
                            m_arm[d][l]  = n + 1;
                        end
                    end
                end
            end
            ncyc = ncyc + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge rck) begin
        logic [3:0] e_ss, e_lost;
        for (int l = 0; l < 4; l++) begin
            e_ss[l]   = m_lock[0][l];
            e_lost[l] = m_lost[0][l];
        end
        chk("cyc_ss_a",   32'(ss_a),   32'(e_ss));
        chk("cyc_lost_a", 32'(lost_a), 32'(e_lost));
        chk("cyc_all_a",  32'(all_a),  32'(m_all[0]));
        chk("cyc_ss_b",   32'(ss_b),   32'(m_lock[1][0]));
        chk("cyc_lost_b", 32'(lost_b), 32'(m_lost[1][0]));
        chk("cyc_all_b",  32'(all_b),  32'(m_all[1]));
    end

    // ---------------- directed stimulus ----------------
    task automatic cycd(input logic [39:0] d);
        rx_data = d;
        @(posedge rck);
        #1;
    endtask

    task automatic cyc(input logic [9:0] w);
        cycd({w, w, w, w});
    endtask

    initial begin
        rst     = 1'b1;
        rearm   = 1'b0;
        lane_en = 4'hF;
        rx_data = '0;
        repeat (2) @(posedge rck);
        #1;
        chk("rst_ss_a",   32'(ss_a),   32'h0);
        chk("rst_all_a",  32'(all_a),  32'h0);
        chk("rst_lost_a", 32'(lost_a), 32'h0);
        chk("rst_ss_b",   32'(ss_b),   32'h0);
        rst = 1'b0;

        // Static prefix then non-static run: lock on the 2nd 0x155.
        repeat (5) cyc(10'h000);
        cyc(10'h155);
        chk("t1_first_word", 32'(ss_a), 32'h0);
        cyc(10'h155);
        chk("t1_lock",       32'(ss_a),  32'hF);
        chk("t1_all_lag",    32'(all_a), 32'h0);
        cyc(10'h155);
        chk("t1_all",        32'(all_a),  32'h1);
        chk("t1_no_lost",    32'(lost_a), 32'h0);
        chk("t1_b_not_yet",  32'(ss_b),   32'h0);

        // Rearm while locked: drop without loss pulse, relock after 2 words.
        rearm = 1'b1;
        cyc(10'h155);
        rearm = 1'b0;
        chk("rearm_ss",   32'(ss_a),   32'h0);
        chk("rearm_lost", 32'(lost_a), 32'h0);
        cyc(10'h155);
        chk("rearm_wait", 32'(ss_a), 32'h0);
        cyc(10'h155);
        chk("rearm_relock", 32'(ss_a), 32'hF);

        // dut_b: 0x155,0x155 (above), 0x3FF breaks the run, then 4x 0x155.
        cyc(10'h3FF);
        chk("t2_break", 32'(ss_b), 32'h0);
        repeat (3) cyc(10'h155);
        chk("t2_third", 32'(ss_b), 32'h0);
        cyc(10'h155);
        chk("t2_lock",  32'(ss_b), 32'h1);
        chk("t2_a_held", 32'(ss_a), 32'hF);

        // Loss on dut_a after 3 consecutive static words.
        cyc(10'h000);
        cyc(10'h000);
        cyc(10'h155);
        cyc(10'h000);
        cyc(10'h000);
        chk("t3_hold_ss",   32'(ss_a),   32'hF);
        chk("t3_hold_lost", 32'(lost_a), 32'h0);
        cyc(10'h000);
        chk("t3_loss_ss",   32'(ss_a),   32'h0);
        chk("t3_loss_lost", 32'(lost_a), 32'hF);
        chk("t3_b_sticky",  32'(ss_b),   32'h1);
        cyc(10'h155);
        chk("t3_pulse_end", 32'(lost_a), 32'h0);
        chk("t3_requal",    32'(ss_a),   32'h0);
        cyc(10'h155);
        chk("t3_relock",    32'(ss_a),   32'hF);

        // Lane enables: lane 2 disabled and static.
        lane_en = 4'b1011;
        cycd({10'h155, 10'h000, 10'h155, 10'h155});
        cycd({10'h155, 10'h000, 10'h155, 10'h155});
        chk("t4_ss",  32'(ss_a),  32'hB);
        chk("t4_all", 32'(all_a), 32'h1);
        lane_en = 4'b1111;
        cycd({10'h155, 10'h000, 10'h155, 10'h155});
        chk("t4_all_drop", 32'(all_a), 32'h0);
        chk("t4_ss_keep",  32'(ss_a),  32'hB);

        // Lock on lane 2 and loss on lanes 0/1/3 on the same edge.
        cycd({10'h000, 10'h000, 10'h000, 10'h000});
        cycd({10'h000, 10'h155, 10'h000, 10'h000});
        cycd({10'h000, 10'h155, 10'h000, 10'h000});
        chk("t5_ss",   32'(ss_a),   32'h4);
        chk("t5_lost", 32'(lost_a), 32'hB);

        // Async reset in mid-qualification, then a full run is needed.
        cyc(10'h155);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_async_ss_a",  32'(ss_a),  32'h0);
        chk("t6_async_ss_b",  32'(ss_b),  32'h0);
        chk("t6_async_all_a", 32'(all_a), 32'h0);
        @(posedge rck);
        #1;
        rst = 1'b0;
        cyc(10'h155);
        chk("t6_first", 32'(ss_a), 32'h0);
        cyc(10'h155);
        chk("t6_lock",  32'(ss_a), 32'hF);
        repeat (2) cyc(10'h155);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
